// File: rtl/ex_muldiv.sv
// Iterative 32-cycle multiply/divide unit with architectural HI/LO registers.
// Optional macro EX_MD_DIV_EN builds the DIV/DIVU datapath; without it op 3/4 act as NOP.
module ex_muldiv (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        EX_md_start,
    input  logic [2:0]  EX_md_op,
    input  logic [31:0] EX_alu_in1,
    input  logic [31:0] EX_alu_in2,
    input  logic        EX_md_flush,
    output logic        EX_md_busy,
    output logic        EX_md_done,
    output logic [31:0] EX_hi,
    output logic [31:0] EX_lo
);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t      state;
    logic [5:0]  count;
    logic [63:0] acc;
    logic [31:0] opnd;
    logic        is_div;
    logic        neg_res;
    logic        neg_rem;

    logic        op_mul;
    logic        op_div;
    logic        op_signed;
    logic        div_zero;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] mul_sum;
    logic [63:0] step_next;
    logic [63:0] product;

    function automatic logic [31:0] neg_if32(input logic [31:0] v, input logic en);
        return en ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [63:0] neg_if64(input logic [63:0] v, input logic en);
        return en ? (~v + 64'd1) : v;
    endfunction

    always_comb begin
        op_mul    = (EX_md_op == 3'd1) || (EX_md_op == 3'd2);
        op_signed = (EX_md_op == 3'd1) || (EX_md_op == 3'd3);
`ifdef EX_MD_DIV_EN
        op_div    = (EX_md_op == 3'd3) || (EX_md_op == 3'd4);
`else
        op_div    = 1'b0;
`endif
        // A zero divisor keeps the raw dividend so the remainder comes out unchanged.
        div_zero  = op_div && (EX_alu_in2 == 32'd0);
        a_mag     = neg_if32(EX_alu_in1, op_signed && EX_alu_in1[31] && !div_zero);
        b_mag     = neg_if32(EX_alu_in2, op_signed && EX_alu_in2[31]);
    end

`ifdef EX_MD_DIV_EN
    logic [32:0] div_trial;
`endif

    always_comb begin
        mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
        step_next = {mul_sum, acc[31:1]};
`ifdef EX_MD_DIV_EN
        // Restoring step: shifted partial remainder is 33 bits wide before the subtract.
        div_trial = acc[63:31] - {1'b0, opnd};
        if (is_div)
            step_next = div_trial[32] ? {acc[62:0], 1'b0}
                                      : {div_trial[31:0], acc[30:0], 1'b1};
`endif
        product   = neg_if64(acc, neg_res);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            count      <= 6'd0;
            acc        <= 64'd0;
            opnd       <= 32'd0;
            is_div     <= 1'b0;
            neg_res    <= 1'b0;
            neg_rem    <= 1'b0;
            EX_md_busy <= 1'b0;
            EX_md_done <= 1'b0;
            EX_hi      <= 32'd0;
            EX_lo      <= 32'd0;
        end else begin
            EX_md_done <= 1'b0;
            if (EX_md_flush) begin
                state      <= IDLE;
                count      <= 6'd0;
                EX_md_busy <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (EX_md_start) begin
                            if (op_div) begin
                                acc        <= {32'd0, a_mag};
                                opnd       <= b_mag;
                                is_div     <= 1'b1;
                                neg_res    <= op_signed && (EX_alu_in1[31] ^ EX_alu_in2[31]) && !div_zero;
                                neg_rem    <= op_signed && EX_alu_in1[31] && !div_zero;
                                count      <= 6'd0;
                                EX_md_busy <= 1'b1;
                                state      <= RUN;
                            end else if (op_mul) begin
                                acc        <= {32'd0, b_mag};
                                opnd       <= a_mag;
                                is_div     <= 1'b0;
                                neg_res    <= op_signed && (EX_alu_in1[31] ^ EX_alu_in2[31]);
                                neg_rem    <= 1'b0;
                                count      <= 6'd0;
                                EX_md_busy <= 1'b1;
                                state      <= RUN;
                            end else if (EX_md_op == 3'd5) begin
                                EX_hi <= EX_alu_in1;
                            end else if (EX_md_op == 3'd6) begin
                                EX_lo <= EX_alu_in1;
                            end
                        end
                    end
                    RUN: begin
                        acc   <= step_next;
                        count <= count + 6'd1;
                        if (count == 6'd31)
                            state <= FIX;
                    end
                    FIX: begin
                        if (is_div) begin
                            EX_lo <= neg_if32(acc[31:0], neg_res);
                            EX_hi <= neg_if32(acc[63:32], neg_rem);
                        end else begin
                            EX_lo <= product[31:0];
                            EX_hi <= product[63:32];
                        end
                        EX_md_busy <= 1'b0;
                        EX_md_done <= 1'b1;
                        state      <= IDLE;
                    end
                    default: begin
                        state      <= IDLE;
                        EX_md_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: vector table plus hand-written flush/reset/busy sequences.
// Divide vectors are exercised only when EX_MD_DIV_EN is defined.
`timescale 1ns/1ps
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        md_start;
    logic [2:0]  md_op;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        md_flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    ex_muldiv dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .EX_md_start (md_start),
        .EX_md_op    (md_op),
        .EX_alu_in1  (in1),
        .EX_alu_in2  (in2),
        .EX_md_flush (md_flush),
        .EX_md_busy  (busy),
        .EX_md_done  (done),
        .EX_hi       (hi),
        .EX_lo       (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ehi;
        logic [31:0] elo;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    vec_t        vecs[$];
    exp_t        scb[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;

    task automatic check_w(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %08h, required %08h", nm, act, req);
        end
    endtask

    task automatic check_b(input string nm, input logic act, input logic req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %b, required %b", nm, act, req);
        end
    endtask

    // Called at a negedge; returns at a negedge (the done cycle for running ops).
    task automatic do_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi,
                         input logic [31:0] elo, input bit runs);
        exp_t e;
        int   cyc;
        md_start = 1'b1;
        md_op    = op;
        in1      = a;
        in2      = b;
        e.hi = ehi;
        e.lo = elo;
        scb.push_back(e);
        @(negedge clk);
        md_start = 1'b0;
        md_op    = 3'd0;
        if (!runs) begin
            e = scb.pop_front();
            check_b({nm, " busy"}, busy, 1'b0);
            check_b({nm, " done"}, done, 1'b0);
            check_w({nm, " hi"}, hi, e.hi);
            check_w({nm, " lo"}, lo, e.lo);
            model_hi = e.hi;
            model_lo = e.lo;
            return;
        end
        check_b({nm, " busy after start"}, busy, 1'b1);
        check_b({nm, " done after start"}, done, 1'b0);
        check_w({nm, " hi held"}, hi, model_hi);
        check_w({nm, " lo held"}, lo, model_lo);
        cyc = 0;
        while (busy === 1'b1 && cyc < 60) begin
            cyc++;
            @(negedge clk);
        end
        check_w({nm, " busy cycles"}, 32'(cyc), 32'd33);
        check_b({nm, " done pulse"}, done, 1'b1);
        e = scb.pop_front();
        check_w({nm, " hi"}, hi, e.hi);
        check_w({nm, " lo"}, lo, e.lo);
        model_hi = e.hi;
        model_lo = e.lo;
    endtask

    task automatic watch_quiet(input string nm, input int n);
        int busy_cnt = 0;
        int done_cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) done_cnt++;
        end
        check_w({nm, " busy count"}, 32'(busy_cnt), 32'd0);
        check_w({nm, " done count"}, 32'(done_cnt), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic        [31:0] a;
        logic        [31:0] b;
        logic signed [63:0] sp;
        logic        [63:0] up;

        vecs.push_back('{"mult_neg",   3'd1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA});
        vecs.push_back('{"multu",      3'd2, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA});
        vecs.push_back('{"mult_min2",  3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000});
        vecs.push_back('{"multu_max",  3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001});
        vecs.push_back('{"mult_zero",  3'd1, 32'd0,        32'h00012345, 32'h00000000, 32'h00000000});
`ifdef EX_MD_DIV_EN
        vecs.push_back('{"div_neg",    3'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD});
        vecs.push_back('{"divu",       3'd4, 32'd100,      32'd7,        32'h00000002, 32'h0000000E});
        vecs.push_back('{"divu_zero",  3'd4, 32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFF});
        vecs.push_back('{"div_ovf",    3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000});
        vecs.push_back('{"div_negdiv", 3'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD});
        vecs.push_back('{"div_zero_s", 3'd3, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF});
`endif

        rst_n    = 1'b0;
        md_start = 1'b0;
        md_op    = 3'd0;
        in1      = 32'd0;
        in2      = 32'd0;
        md_flush = 1'b0;
        repeat (2) @(negedge clk);
        check_w("reset hi", hi, 32'd0);
        check_w("reset lo", lo, 32'd0);
        check_b("reset busy", busy, 1'b0);
        check_b("reset done", done, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table vectors chained back to back: each start lands in the previous done cycle.
        foreach (vecs[i])
            do_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ehi, vecs[i].elo, 1'b1);
        @(negedge clk);
        check_b("done single cycle", done, 1'b0);

        for (int i = 0; i < 6; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 2 == 0) begin
                sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                do_op($sformatf("rand_mult%0d", i), 3'd1, a, b, sp[63:32], sp[31:0], 1'b1);
            end else begin
                up = {32'd0, a} * {32'd0, b};
                do_op($sformatf("rand_multu%0d", i), 3'd2, a, b, up[63:32], up[31:0], 1'b1);
            end
        end
`ifdef EX_MD_DIV_EN
        for (int i = 0; i < 4; i++) begin
            logic signed [31:0] sa;
            logic signed [31:0] sbv;
            a = $urandom;
            b = ($urandom & ~32'h1) | 32'h2;
            if (i % 2 == 0) begin
                sa  = a;
                sbv = b;
                do_op($sformatf("rand_div%0d", i), 3'd3, a, b, 32'(sa % sbv), 32'(sa / sbv), 1'b1);
            end else begin
                b = b >> (i * 5);
                do_op($sformatf("rand_divu%0d", i), 3'd4, a, b, a % b, a / b, 1'b1);
            end
        end
`endif
        @(negedge clk);

        do_op("mthi", 3'd5, 32'hAAAA5555, 32'd0, 32'hAAAA5555, model_lo, 1'b0);
        do_op("mtlo", 3'd6, 32'h0F0F1234, 32'd0, 32'hAAAA5555, 32'h0F0F1234, 1'b0);

        // MULT flushed at cycle 10, with an MTLO attempted while busy.
        md_start = 1'b1;
        md_op    = 3'd1;
        in1      = 32'd3;
        in2      = 32'd5;
        @(negedge clk);
        md_start = 1'b0;
        repeat (4) @(negedge clk);
        md_start = 1'b1;
        md_op    = 3'd6;
        in1      = 32'hDEADBEEF;
        @(negedge clk);
        md_start = 1'b0;
        md_op    = 3'd0;
        check_b("busy during run", busy, 1'b1);
        repeat (4) @(negedge clk);
        md_flush = 1'b1;
        @(negedge clk);
        md_flush = 1'b0;
        check_b("flush busy", busy, 1'b0);
        check_b("flush done", done, 1'b0);
        check_w("flush hi", hi, 32'hAAAA5555);
        check_w("flush lo", lo, 32'h0F0F1234);
        watch_quiet("after flush", 40);
        check_w("mtlo ignored while busy", lo, 32'h0F0F1234);

        // Flush together with start: nothing is launched.
        md_start = 1'b1;
        md_flush = 1'b1;
        md_op    = 3'd2;
        in1      = 32'd9;
        in2      = 32'd9;
        @(negedge clk);
        md_start = 1'b0;
        md_flush = 1'b0;
        watch_quiet("flush+start", 40);
        check_w("flush+start hi", hi, 32'hAAAA5555);

        // Asynchronous reset in the middle of a MULT.
        md_start = 1'b1;
        md_op    = 3'd1;
        in1      = 32'd7;
        in2      = 32'd9;
        @(negedge clk);
        md_start = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_w("midreset hi", hi, 32'd0);
        check_w("midreset lo", lo, 32'd0);
        check_b("midreset busy", busy, 1'b0);
        check_b("midreset done", done, 1'b0);
        @(negedge clk);
        rst_n    = 1'b1;
        model_hi = 32'd0;
        model_lo = 32'd0;
        watch_quiet("after reset", 40);
        check_w("post reset lo", lo, 32'd0);

`ifndef EX_MD_DIV_EN
        do_op("mthi2", 3'd5, 32'h5A5A0001, 32'd0, 32'h5A5A0001, 32'd0, 1'b0);
        md_start = 1'b1;
        md_op    = 3'd3;
        in1      = 32'd100;
        in2      = 32'd7;
        @(negedge clk);
        md_start = 1'b0;
        md_op    = 3'd0;
        check_b("div disabled busy", busy, 1'b0);
        watch_quiet("div disabled", 40);
        check_w("div disabled hi", hi, 32'h5A5A0001);
        check_w("div disabled lo", lo, 32'd0);
`endif

        do_op("final_mult", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd1, 1'b1);
        @(negedge clk);
        check_b("final done low", done, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
